// File: rtl/maxpool_stage_pkg.sv
// maxpool_stage shared package
// Pixel type, FSM encoding and the signed max helper.
package maxpool_stage_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] pix_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Ties keep the earlier operand a.
    function automatic pix_t smax(input pix_t a, input pix_t b);
        return (b > a) ? b : a;
    endfunction

endpackage

// File: rtl/maxpool_stage_if.sv
// maxpool_stage control and stream interface
// master = producer/consumer side, slave = pooling stage.
interface maxpool_stage_if;

    logic                      go;
    logic                      relu_en;
    logic                      in_valid;
    maxpool_stage_pkg::pix_t   in_data;
    logic                      in_ready;
    logic                      out_valid;
    maxpool_stage_pkg::pix_t   out_data;
    logic                      out_ready;
    logic                      busy;
    logic                      done;

    modport master (
        output go, relu_en, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, done
    );

    modport slave (
        input  go, relu_en, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, done
    );

endinterface

// File: rtl/pool_linebuf.sv
// pool_linebuf: one row of horizontal pair maxima
// Single write port, asynchronous read port, no reset on contents.
module pool_linebuf #(
    parameter int DEPTH = 4,
    parameter int W     = 16,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Store the even-row pair maximum for its column pair
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool_stage.sv
// maxpool_stage: 2x2 stride-2 max pooling over a raster pixel stream
// Optional ReLU on the pooled value; one map per go.
module maxpool_stage
    import maxpool_stage_pkg::*;
#(
    parameter int MAP_W = 8,
    parameter int MAP_H = 8
) (
    input logic             clk,
    input logic             rst,
    maxpool_stage_if.slave  bus
);

    localparam int CW   = $clog2(MAP_W);
    localparam int RW   = $clog2(MAP_H);
    localparam int LB_D = MAP_W / 2;
    localparam int AW   = (LB_D > 1) ? $clog2(LB_D) : 1;

    state_t          state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    pix_t            pair;
    logic            relu;
    logic            ov;
    pix_t            od;
    logic            busy_q;
    logic            done_q;

    pix_t            pmax;
    pix_t            lb_rd;
    pix_t            pooled;
    pix_t            res;
    logic [AW-1:0]   lb_addr;
    logic            ready;
    logic            accept;
    logic            consume;
    logic            start;
    logic            col_last;
    logic            row_last;
    logic            lb_we;
    logic            load;
    logic            last;

    assign ready    = (state == S_RUN) && !(ov && !bus.out_ready);
    assign accept   = bus.in_valid && ready;
    assign consume  = ov && bus.out_ready;
    assign start    = (state == S_IDLE) && bus.go;
    assign col_last = (col == CW'(MAP_W - 1));
    assign row_last = (row == RW'(MAP_H - 1));
    assign last     = accept && col_last && row_last;

    assign pmax    = smax(pair, bus.in_data);
    assign lb_addr = AW'(col >> 1);
    assign lb_we   = accept && col[0] && !row[0];
    assign load    = accept && col[0] && row[0];
    assign pooled  = smax(lb_rd, pmax);
    assign res     = (relu && pooled[DATA_W-1]) ? '0 : pooled;

    pool_linebuf #(
        .DEPTH (LB_D),
        .W     (DATA_W),
        .AW    (AW)
    ) u_linebuf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (pmax),
        .raddr (lb_addr),
        .rdata (lb_rd)
    );

    // Map sequencing: state, busy/done flags and ReLU latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            relu   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.go) begin
                        state  <= S_RUN;
                        busy_q <= 1'b1;
                        relu   <= bus.relu_en;
                    end
                end
                S_RUN: begin
                    if (last) state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (!ov || bus.out_ready) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Raster position counters and the even-column pair register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col  <= '0;
            row  <= '0;
            pair <= '0;
        end else if (start) begin
            col  <= '0;
            row  <= '0;
            pair <= '0;
        end else if (accept) begin
            if (!col[0]) pair <= bus.in_data;
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Output holding register; reload may coincide with consumption
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ov <= 1'b0;
            od <= '0;
        end else if (load) begin
            ov <= 1'b1;
            od <= res;
        end else if (consume) begin
            ov <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = ov;
    assign bus.out_data  = od;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
